// File: rtl/knn_vote_ctrl.sv
// knn_vote_ctrl: sequences the distance sorter, scans the K nearest sorted
// labels, runs a majority vote (ties go to the class with the nearest member)
// and reports the winning class with a one-cycle strobe.
module knn_vote_ctrl #(
    parameter int unsigned N       = 64,
    parameter int unsigned B       = 32,
    parameter int unsigned K       = 5,
    parameter int unsigned C       = 8,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 sort_done,
    input  logic                 valid_sort,
    output logic [$clog2(N)-1:0] rd_idx,
    input  logic [B-1:0]         type_in,
    output logic [B-1:0]         class_out,
    output logic                 class_valid,
    output logic                 err
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(K + 1);
    localparam int unsigned LW = (C > 1) ? $clog2(C) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_KICK, S_WAIT, S_SCAN, S_DECIDE, S_OUT
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0] counts    [C];
    logic [IW-1:0] first_idx [C];
    logic [CW-1:0] votes;
    logic [TW-1:0] timer;
    logic          prev_vs;
    logic [LW-1:0] dec_idx;
    logic [CW-1:0] best_count;
    logic [IW-1:0] best_first;
    logic [LW-1:0] best_class;

    logic          busy_nx, sort_done_nx, class_valid_nx, err_nx;
    logic [B-1:0]  class_out_nx;

    logic          sort_edge, timer_done, scan_last, dec_last;
    logic          label_ok, take;
    logic [LW-1:0] label, win_class;
    logic [CW-1:0] cand_count;
    logic [IW-1:0] cand_first;

    // Decode helpers shared by the FSM and the datapath
    always_comb begin
        sort_edge  = valid_sort & ~prev_vs;
        timer_done = (timer == TW'(TIMEOUT - 1));
        scan_last  = (rd_idx == IW'(K - 1));
        dec_last   = (dec_idx == LW'(C - 1));
        label_ok   = (type_in < B'(C));
        label      = LW'(type_in);
        cand_count = counts[dec_idx];
        cand_first = first_idx[dec_idx];
        take       = (cand_count > best_count) ||
                     ((cand_count == best_count) && (cand_count != '0) &&
                      (cand_first < best_first));
        win_class  = take ? dec_idx : best_class;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (start) state_nx = S_KICK;
            S_KICK:   state_nx = S_WAIT;
            S_WAIT: begin
                if (sort_edge)       state_nx = S_SCAN;
                else if (timer_done) state_nx = S_OUT;
            end
            S_SCAN:   if (scan_last) state_nx = S_DECIDE;
            S_DECIDE: if (dec_last)  state_nx = S_OUT;
            S_OUT:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        busy_nx        = (state_nx != S_IDLE);
        sort_done_nx   = (state_nx == S_KICK);
        class_valid_nx = (state_nx == S_OUT);
        err_nx         = 1'b0;
        class_out_nx   = class_out;
        if (state_nx == S_OUT) begin
            if ((state == S_WAIT) || (votes == '0)) begin
                class_out_nx = '1;
                err_nx       = 1'b1;
            end else begin
                class_out_nx = B'(win_class);
            end
        end
    end

    // Output registers, vote counters, timer and serial decision datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            sort_done   <= 1'b0;
            class_valid <= 1'b0;
            err         <= 1'b0;
            class_out   <= '0;
            rd_idx      <= '0;
            votes       <= '0;
            timer       <= '0;
            prev_vs     <= 1'b0;
            dec_idx     <= '0;
            best_count  <= '0;
            best_first  <= '1;
            best_class  <= '0;
            for (int c = 0; c < int'(C); c++) begin
                counts[c]    <= '0;
                first_idx[c] <= '0;
            end
        end else begin
            busy        <= busy_nx;
            sort_done   <= sort_done_nx;
            class_valid <= class_valid_nx;
            err         <= err_nx;
            class_out   <= class_out_nx;
            prev_vs     <= valid_sort;
            case (state)
                S_KICK: begin
                    for (int c = 0; c < int'(C); c++) begin
                        counts[c]    <= '0;
                        first_idx[c] <= '0;
                    end
                    votes      <= '0;
                    timer      <= '0;
                    rd_idx     <= '0;
                    dec_idx    <= '0;
                    best_count <= '0;
                    best_first <= '1;
                    best_class <= '0;
                end
                S_WAIT: timer <= timer + TW'(1);
                S_SCAN: begin
                    if (label_ok) begin
                        counts[label] <= counts[label] + CW'(1);
                        if (counts[label] == '0) first_idx[label] <= rd_idx;
                        votes <= votes + CW'(1);
                    end
                    rd_idx <= scan_last ? '0 : rd_idx + IW'(1);
                end
                S_DECIDE: begin
                    if (take) begin
                        best_count <= cand_count;
                        best_first <= cand_first;
                        best_class <= dec_idx;
                    end
                    dec_idx <= dec_last ? '0 : dec_idx + LW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
